stump_mem_responder: RTL and testbench
======================================

STUMP_MEM_RESPONDER -- requirements
Module: stump_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 16-bit words in the internal RAM; power of two, 16..4096.
REQ-002 Parameter WAIT_STATES, default 2: wait cycles inserted before a response; legal range 0..15.
REQ-003 Port clk  input  1: clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port mem_ren  input  1: read request from the Stump datapath/control.
REQ-006 Port mem_wen  input  1: write request from the Stump datapath/control.
REQ-007 Port addr  input  16: word address.
REQ-008 Port wdata  input  16: write data.
REQ-009 Port rdata  output  16: read data.
REQ-010 Port ready  output  1: one-cycle completion strobe for the accepted access.
REQ-011 Port busy  output  1: high while an accepted access is outstanding (WAIT or RESP).
REQ-012 Port err  output  1: access error strobe; present only when STUMP_MEM_ERR_EN is defined.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-014 In IDLE, mem_ren or mem_wen high SHALL accept a request and latch addr, wdata, and the op into internal registers.
REQ-015 If mem_ren and mem_wen are both high at acceptance, the access SHALL be a write; the read is discarded.
REQ-016 On acceptance, the FSM SHALL go to WAIT with the wait counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else straight to RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP.
REQ-018 Counter width SHALL be 4 bits; the counter SHALL never wrap below 0.
REQ-019 In RESP, ready SHALL be high for exactly one cycle and the FSM SHALL return to IDLE unconditionally.
REQ-020 Latency: ready SHALL rise WAIT_STATES+1 cycles after the accepting edge.
REQ-021 A write SHALL commit the latched wdata to RAM[addr mod DEPTH] on the RESP edge only.
REQ-022 For a read, rdata SHALL present RAM[latched addr mod DEPTH] during the RESP cycle and hold it until the next read's RESP.
REQ-023 rdata SHALL NOT change on writes.
REQ-024 Requests in WAIT or RESP SHALL be ignored.
REQ-025 A request still high in the IDLE cycle after RESP SHALL be accepted as a new access; the requester drops the enable on seeing ready.
REQ-026 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-027 Address bits above log2(DEPTH) SHALL be ignored when STUMP_MEM_ERR_EN is undefined.

Reset
REQ-028 rst SHALL force IDLE, counter 0, ready 0, busy 0, err 0, rdata 16'h0000, and latched registers 0.
REQ-029 rst during WAIT SHALL abort the access, and a pending write SHALL NOT be committed.
REQ-030 RAM contents SHALL NOT be reset.

Configuration
REQ-031 When macro STUMP_MEM_ERR_EN is defined, an access with addr >= DEPTH SHALL still pass through WAIT/RESP with normal latency.
REQ-032 Such an out-of-range access SHALL raise err together with ready.
REQ-033 An out-of-range write SHALL NOT be committed.
REQ-034 An out-of-range read SHALL set rdata to 16'hDEAD.
REQ-035 When STUMP_MEM_ERR_EN is undefined, the err port and its logic SHALL be absent and addresses SHALL alias per REQ-027.

Structure
REQ-036 Shared package stump_mem_pkg SHALL hold the FSM state encodings, default DEPTH/WAIT_STATES constants and ERR_RDATA = 16'hDEAD.
REQ-037 RAM storage SHALL be a sub-module stump_mem_array: single-port, synchronous write, asynchronous read, parameterised by DEPTH.

Verification
REQ-038 WAIT_STATES=2: write 16'h1234 to 0x0010, then read 0x0010 -> ready 3 cycles after each accept; rdata=16'h1234 in the read RESP cycle.
REQ-039 WAIT_STATES=0: read with ren held high 3 cycles -> ready every other cycle; busy toggles 1/0.
REQ-040 mem_ren=mem_wen=1, addr 0x0005, wdata 16'hBEEF -> write performed; rdata unchanged; a later read of 0x0005 returns 16'hBEEF.
REQ-041 rst asserted in WAIT of a write of 16'hAAAA to 0x0003 holding 16'h5555 -> outputs cleared immediately; a later read returns 16'h5555.
REQ-042 STUMP_MEM_ERR_EN, DEPTH=256, read 0x0100 -> err=ready=1 for one cycle, rdata=16'hDEAD; a write to 0x0100 leaves RAM[0x00] unchanged.
REQ-043 Requests pulsed during WAIT -> no extra ready; exactly one ready per accepted access.

Source files
------------

// File: rtl/stump_mem_pkg.sv
// Shared definitions for the Stump memory responder: FSM encodings, defaults,
// the latched-request record and the out-of-range read pattern.
package stump_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_STATES = 2;
  localparam int CNT_W               = 4;

  localparam logic [15:0] ERR_RDATA = 16'hDEAD;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  // Counter preload: the first WAIT cycle already counts as one wait state.
  function automatic logic [CNT_W-1:0] wait_load(input int ws);
    return (ws > 0) ? CNT_W'(ws - 1) : '0;
  endfunction

endpackage

// File: rtl/stump_mem_array.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset on
// storage so contents survive rst.
module stump_mem_array
  import stump_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/stump_mem_responder.sv
// Wait-state memory responder for the Stump core: IDLE -> WAIT -> RESP.
// Define STUMP_MEM_ERR_EN to add range checking and the err strobe.
module stump_mem_responder
  import stump_mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
`ifdef STUMP_MEM_ERR_EN
  output logic        busy,
  output logic        err
`else
  output logic        busy
`endif
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;
  logic [15:0]      rdata_q, rdata_d;

  logic        mem_we;
  logic        in_range;
  logic [15:0] arr_rdata;
  logic [15:0] rd_value;

`ifdef STUMP_MEM_ERR_EN
  assign in_range = (req_q.addr < 16'(DEPTH));
  assign err      = (state_q == ST_RESP) && !in_range;
`else
  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr_hi;
  assign in_range       = 1'b1;
  assign unused_addr_hi = ^req_q.addr[15:AW];
`endif

  assign rd_value = in_range ? arr_rdata : ERR_RDATA;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_ren || mem_wen) begin
          // A simultaneous read and write resolves to the write.
          req_d.wr    = mem_wen;
          req_d.addr  = addr;
          req_d.wdata = wdata;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (req_q.wr) begin
          mem_we = in_range;
        end else begin
          rdata_d = rd_value;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  stump_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (req_q.addr[AW-1:0]),
    .wdata(req_q.wdata),
    .rdata(arr_rdata)
  );

  // Read data goes live in the RESP cycle and is held afterwards from rdata_q.
  assign rdata = ((state_q == ST_RESP) && !req_q.wr) ? rd_value : rdata_q;
  assign ready = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stump_mem_responder.sv
// Directed bench for stump_mem_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance; honours STUMP_MEM_ERR_EN when defined.
module tb_stump_mem_responder;

  logic clk;
  logic rst;

  logic        a_ren, a_wen, a_ready, a_busy;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_ren, b_wen, b_ready, b_busy;
  logic [15:0] b_addr, b_wdata, b_rdata;
`ifdef STUMP_MEM_ERR_EN
  logic a_err, b_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  stump_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .rst(rst), .mem_ren(a_ren), .mem_wen(a_wen),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready),
`ifdef STUMP_MEM_ERR_EN
    .busy(a_busy), .err(a_err)
`else
    .busy(a_busy)
`endif
  );

  stump_mem_responder #(.DEPTH(16), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .rst(rst), .mem_ren(b_ren), .mem_wen(b_wen),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready),
`ifdef STUMP_MEM_ERR_EN
    .busy(b_busy), .err(b_err)
`else
    .busy(b_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance A; lat counts cycles from the request cycle to ready.
  task automatic acc(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] rdv, output logic errv,
                     output logic busy1);
    a_wen = wr; a_ren = rd; a_addr = a; a_wdata = d;
    @(posedge clk); #1;
    a_wen = 1'b0; a_ren = 1'b0;
    lat   = 1;
    busy1 = a_busy;
    while (!a_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdv = a_rdata;
`ifdef STUMP_MEM_ERR_EN
    errv = a_err;
`else
    errv = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [15:0] rdv;
    logic        errv, busy1;
    int          n_rdy;
    int          exp_rdy [5] = '{1, 0, 1, 0, 0};

    rst = 1'b1;
    a_ren = 0; a_wen = 0; a_addr = 0; a_wdata = 0;
    b_ren = 0; b_wen = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_rdata", a_rdata, 16'h0000);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_b_busy", b_busy, 0);
`ifdef STUMP_MEM_ERR_EN
    chk("rst_a_err", a_err, 0);
`endif
    rst = 1'b0;

    // Write then read 0x0010 with two wait states.
    acc(1, 0, 16'h0010, 16'h1234, lat, rdv, errv, busy1);
    chk("wr10_lat", lat, 3);
    chk("wr10_busy_wait", busy1, 1);
    chk("wr10_rdata_unchanged", rdv, 16'h0000);
    chk("wr10_ready_one_cycle", a_ready, 0);
    chk("wr10_idle_busy", a_busy, 0);
    acc(0, 1, 16'h0010, 16'h0000, lat, rdv, errv, busy1);
    chk("rd10_lat", lat, 3);
    chk("rd10_rdata", rdv, 16'h1234);
    chk("rd10_rdata_hold", a_rdata, 16'h1234);

    // Read and write together: the write wins, rdata keeps its value.
    acc(1, 1, 16'h0005, 16'hBEEF, lat, rdv, errv, busy1);
    chk("both_lat", lat, 3);
    chk("both_rdata_unchanged", rdv, 16'h1234);
    acc(0, 1, 16'h0005, 16'h0000, lat, rdv, errv, busy1);
    chk("rd05_rdata", rdv, 16'hBEEF);

    // Reset in the middle of a write aborts it.
    acc(1, 0, 16'h0003, 16'h5555, lat, rdv, errv, busy1);
    a_wen = 1; a_addr = 16'h0003; a_wdata = 16'hAAAA;
    @(posedge clk); #1;
    a_wen = 0;
    chk("abort_busy_before", a_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_ready", a_ready, 0);
    chk("abort_rdata", a_rdata, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    acc(0, 1, 16'h0003, 16'h0000, lat, rdv, errv, busy1);
    chk("abort_rd03", rdv, 16'h5555);

    // Requests arriving during WAIT/RESP are ignored.
    acc(1, 0, 16'h0030, 16'h1111, lat, rdv, errv, busy1);
    n_rdy = 0;
    a_wen = 1; a_addr = 16'h0020; a_wdata = 16'h7777;
    @(posedge clk); #1;
    n_rdy += int'(a_ready);
    a_addr = 16'h0030; a_wdata = 16'h9999; a_ren = 1;
    repeat (2) begin
      @(posedge clk); #1;
      n_rdy += int'(a_ready);
    end
    a_wen = 0; a_ren = 0;
    repeat (5) begin
      @(posedge clk); #1;
      n_rdy += int'(a_ready);
    end
    chk("ignore_ready_count", n_rdy, 1);
    acc(0, 1, 16'h0020, 16'h0000, lat, rdv, errv, busy1);
    chk("ignore_rd20", rdv, 16'h7777);
    acc(0, 1, 16'h0030, 16'h0000, lat, rdv, errv, busy1);
    chk("ignore_rd30", rdv, 16'h1111);

    // Address 0x0100 on a 256-word RAM.
    acc(1, 0, 16'h0000, 16'h0A0A, lat, rdv, errv, busy1);
`ifdef STUMP_MEM_ERR_EN
    acc(0, 1, 16'h0100, 16'h0000, lat, rdv, errv, busy1);
    chk("oor_rd_lat", lat, 3);
    chk("oor_rd_err", errv, 1);
    chk("oor_rd_rdata", rdv, 16'hDEAD);
    chk("oor_err_one_cycle", a_err, 0);
    acc(1, 0, 16'h0100, 16'hFFFF, lat, rdv, errv, busy1);
    chk("oor_wr_err", errv, 1);
    acc(0, 1, 16'h0000, 16'h0000, lat, rdv, errv, busy1);
    chk("oor_ram0_kept", rdv, 16'h0A0A);
    chk("inrange_no_err", errv, 0);
`else
    acc(0, 1, 16'h0100, 16'h0000, lat, rdv, errv, busy1);
    chk("alias_rd_lat", lat, 3);
    chk("alias_rd", rdv, 16'h0A0A);
    acc(1, 0, 16'h0100, 16'h0B0B, lat, rdv, errv, busy1);
    acc(0, 1, 16'h0000, 16'h0000, lat, rdv, errv, busy1);
    chk("alias_wr", rdv, 16'h0B0B);
`endif

    // Zero wait states on instance B.
    b_wen = 1; b_addr = 16'h0003; b_wdata = 16'h00C3;
    @(posedge clk); #1;
    chk("b_wr_ready", b_ready, 1);
    chk("b_wr_busy", b_busy, 1);
    b_wen = 0;
    @(posedge clk); #1;
    chk("b_idle_ready", b_ready, 0);
    b_ren = 1;
    #1;
    chk("b_req_cycle_busy", b_busy, 0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b_ready_c%0d", i), b_ready, exp_rdy[i-1]);
      chk($sformatf("b_busy_c%0d", i), b_busy, exp_rdy[i-1]);
      if (i == 3) b_ren = 0;
    end
    chk("b_rdata", b_rdata, 16'h00C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
